hazard_info_pipe: RTL and testbench

- Producer side of the pipeline hazard interface: carries each instruction's destination register, write enable and remaining-cycles-to-result (Tnew) from D through E, M and W.
- Drives the A3/W/Tnew inputs consumed by the stall detector.
- Inserts an E-stage bubble when the stall detector asserts stall.
- Generates forwarding-mux selects for the D, E and M operand ports, plus a saturating stall-cycle counter for performance debug.

---
 rtl/hazard_info_pipe_pkg.sv | 24 ++
 rtl/hazard_info_pipe_if.sv | 32 +++
 rtl/hazard_info_pipe_fwd_sel.sv | 34 +++
 rtl/hazard_info_pipe.sv | 125 ++++++++++++
 tb/tb_hazard_info_pipe.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/hazard_info_pipe_pkg.sv
// Shared types and encodings for the hazard-info pipeline and its forwarding selects.
package hazard_info_pipe_pkg;

  typedef logic [4:0] reg_idx_t;
  typedef logic [1:0] tnew_t;
  typedef logic [1:0] fwd_t;

  // Forward-mux select codes, higher value = nearer stage.
  localparam fwd_t FWD_RF = 2'd0;
  localparam fwd_t FWD_W  = 2'd1;
  localparam fwd_t FWD_M  = 2'd2;
  localparam fwd_t FWD_E  = 2'd3;

  // Cycles until the result exists, measured at E entry.
  localparam tnew_t TNEW_LOAD = 2'd2;
  localparam tnew_t TNEW_ALU  = 2'd1;
  localparam tnew_t TNEW_LINK = 2'd0;

  // One stage of progress toward the result, never below zero.
  function automatic tnew_t tnew_dec(tnew_t t);
    return (t == TNEW_LINK) ? TNEW_LINK : tnew_t'(t - 2'd1);
  endfunction

endpackage

// File: rtl/hazard_info_pipe_if.sv
// D-stage inputs, per-stage hazard info and forwarding selects.
// slave = the hazard_info_pipe block, master = the surrounding pipeline.
interface hazard_info_pipe_if #(
  parameter int unsigned CNT_W = 32
);
  import hazard_info_pipe_pkg::*;

  reg_idx_t         A1_D, A2_D, A3_D;
  logic             W_D;
  tnew_t            Tnew_D;
  logic             stall;

  reg_idx_t         A3_E, A3_M, A3_W;
  logic             W_E, W_M, W_W;
  tnew_t            Tnew_E, Tnew_M;
  reg_idx_t         A1_E, A2_E, A2_M;
  fwd_t             FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M;
  logic [CNT_W-1:0] stall_cnt;

  modport slave (
    input  A1_D, A2_D, A3_D, W_D, Tnew_D, stall,
    output A3_E, A3_M, A3_W, W_E, W_M, W_W, Tnew_E, Tnew_M, A1_E, A2_E, A2_M,
           FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M, stall_cnt
  );

  modport master (
    output A1_D, A2_D, A3_D, W_D, Tnew_D, stall,
    input  A3_E, A3_M, A3_W, W_E, W_M, W_W, Tnew_E, Tnew_M, A1_E, A2_E, A2_M,
           FwdRS_D, FwdRT_D, FwdRS_E, FwdRT_E, FwdRT_M, stall_cnt
  );

endinterface

// File: rtl/hazard_info_pipe_fwd_sel.sv
// Priority matcher: nearest producing stage (E, then M, then W) that writes src_i decides.
// Slot 2 = E, 1 = M, 0 = W. Tie a slot's write enable low to exclude that stage.
module hazard_info_pipe_fwd_sel
  import hazard_info_pipe_pkg::*;
(
  input  reg_idx_t       src_i,
  input  reg_idx_t [2:0] a3_i,
  input  logic     [2:0] we_i,
  input  tnew_t    [2:0] tnew_i,
  output fwd_t           code_o
);

  logic [2:0] hit;

  // A stage matches when it writes the same non-zero register.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      hit[i] = we_i[i] && (a3_i[i] == src_i) && (src_i != '0);
    end
  end

  // Nearest match wins; a result that is not ready yet falls back to the register file.
  always_comb begin
    code_o = FWD_RF;
    if (hit[2]) begin
      code_o = (tnew_i[2] == '0) ? FWD_E : FWD_RF;
    end else if (hit[1]) begin
      code_o = (tnew_i[1] == '0) ? FWD_M : FWD_RF;
    end else if (hit[0]) begin
      code_o = (tnew_i[0] == '0) ? FWD_W : FWD_RF;
    end
  end

endmodule

// File: rtl/hazard_info_pipe.sv
// Carries destination/write-enable/Tnew from D through E, M, W, bubbles E on stall,
// and derives the forwarding selects for the D, E and M operand ports.
module hazard_info_pipe
  import hazard_info_pipe_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input logic                clk,
  input logic                reset,
  hazard_info_pipe_if.slave  bus
);

  reg_idx_t         a1_e_q, a2_e_q, a3_e_q;
  logic             we_e_q;
  tnew_t            tnew_e_q;
  reg_idx_t         a2_m_q, a3_m_q;
  logic             we_m_q;
  tnew_t            tnew_m_q;
  reg_idx_t         a3_w_q;
  logic             we_w_q;
  logic [CNT_W-1:0] cnt_q;

  // Stage registers: E takes D or a bubble, M and W always advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a1_e_q   <= '0;
      a2_e_q   <= '0;
      a3_e_q   <= '0;
      we_e_q   <= 1'b0;
      tnew_e_q <= '0;
      a2_m_q   <= '0;
      a3_m_q   <= '0;
      we_m_q   <= 1'b0;
      tnew_m_q <= '0;
      a3_w_q   <= '0;
      we_w_q   <= 1'b0;
    end else begin
      if (bus.stall) begin
        a1_e_q   <= '0;
        a2_e_q   <= '0;
        a3_e_q   <= '0;
        we_e_q   <= 1'b0;
        tnew_e_q <= '0;
      end else begin
        a1_e_q   <= bus.A1_D;
        a2_e_q   <= bus.A2_D;
        a3_e_q   <= bus.A3_D;
        we_e_q   <= bus.W_D;
        tnew_e_q <= bus.Tnew_D;
      end
      a2_m_q   <= a2_e_q;
      a3_m_q   <= a3_e_q;
      we_m_q   <= we_e_q;
      tnew_m_q <= tnew_dec(tnew_e_q);
      a3_w_q   <= a3_m_q;
      we_w_q   <= we_m_q;
    end
  end

  // Stall-cycle counter, sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (bus.stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.A1_E      = a1_e_q;
  assign bus.A2_E      = a2_e_q;
  assign bus.A3_E      = a3_e_q;
  assign bus.W_E       = we_e_q;
  assign bus.Tnew_E    = tnew_e_q;
  assign bus.A2_M      = a2_m_q;
  assign bus.A3_M      = a3_m_q;
  assign bus.W_M       = we_m_q;
  assign bus.Tnew_M    = tnew_m_q;
  assign bus.A3_W      = a3_w_q;
  assign bus.W_W       = we_w_q;
  assign bus.stall_cnt = cnt_q;

  // D consumers see E, M and W.
  hazard_info_pipe_fwd_sel u_fwd_rs_d (
    .src_i  (bus.A1_D),
    .a3_i   ({a3_e_q, a3_m_q, a3_w_q}),
    .we_i   ({we_e_q, we_m_q, we_w_q}),
    .tnew_i ({tnew_e_q, tnew_m_q, TNEW_LINK}),
    .code_o (bus.FwdRS_D)
  );

  hazard_info_pipe_fwd_sel u_fwd_rt_d (
    .src_i  (bus.A2_D),
    .a3_i   ({a3_e_q, a3_m_q, a3_w_q}),
    .we_i   ({we_e_q, we_m_q, we_w_q}),
    .tnew_i ({tnew_e_q, tnew_m_q, TNEW_LINK}),
    .code_o (bus.FwdRT_D)
  );

  // E consumers see M and W only.
  hazard_info_pipe_fwd_sel u_fwd_rs_e (
    .src_i  (a1_e_q),
    .a3_i   ({5'd0, a3_m_q, a3_w_q}),
    .we_i   ({1'b0, we_m_q, we_w_q}),
    .tnew_i ({TNEW_LINK, tnew_m_q, TNEW_LINK}),
    .code_o (bus.FwdRS_E)
  );

  hazard_info_pipe_fwd_sel u_fwd_rt_e (
    .src_i  (a2_e_q),
    .a3_i   ({5'd0, a3_m_q, a3_w_q}),
    .we_i   ({1'b0, we_m_q, we_w_q}),
    .tnew_i ({TNEW_LINK, tnew_m_q, TNEW_LINK}),
    .code_o (bus.FwdRT_E)
  );

  // Store data in M sees W only.
  hazard_info_pipe_fwd_sel u_fwd_rt_m (
    .src_i  (a2_m_q),
    .a3_i   ({5'd0, 5'd0, a3_w_q}),
    .we_i   ({1'b0, 1'b0, we_w_q}),
    .tnew_i ({TNEW_LINK, TNEW_LINK, TNEW_LINK}),
    .code_o (bus.FwdRT_M)
  );

endmodule

// File: tb/tb_hazard_info_pipe.sv
// Directed bench for hazard_info_pipe: pipeline movement, bubbles, forwarding, counter.
module tb_hazard_info_pipe;
  import hazard_info_pipe_pkg::*;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_info_pipe_if #(.CNT_W(32)) bus ();
  hazard_info_pipe_if #(.CNT_W(3))  bus3 ();

  hazard_info_pipe #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  hazard_info_pipe #(.CNT_W(3)) dut3 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_d(input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] a3,
                         input logic we, input logic [1:0] tn);
    bus.A1_D   = a1;
    bus.A2_D   = a2;
    bus.A3_D   = a3;
    bus.W_D    = we;
    bus.Tnew_D = tn;
  endtask

  task automatic flush();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    bus.stall = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    bus.stall = 1'b0;
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    bus3.A1_D = '0; bus3.A2_D = '0; bus3.A3_D = '0;
    bus3.W_D  = 1'b0; bus3.Tnew_D = '0; bus3.stall = 1'b0;
    #12;
    check("rst_w_e", 32'(bus.W_E), 0);
    check("rst_a3_w", 32'(bus.A3_W), 0);
    check("rst_cnt", bus.stall_cnt, 0);
    reset = 1'b0;
    tick();

    // ALU chain: r8 written with Tnew 1, then read in D and later in E.
    drive_d(5'd0, 5'd0, 5'd8, 1'b1, TNEW_ALU);
    tick();
    drive_d(5'd8, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("alu_tnew_e", 32'(bus.Tnew_E), 1);
    check("alu_fwdrs_d", 32'(bus.FwdRS_D), 32'(FWD_RF));
    tick();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("alu_a3_m", 32'(bus.A3_M), 8);
    check("alu_tnew_m", 32'(bus.Tnew_M), 0);
    check("alu_fwdrs_e", 32'(bus.FwdRS_E), 32'(FWD_M));
    flush();

    // Load-use: load r9, dependent reader stalls one cycle.
    drive_d(5'd0, 5'd0, 5'd9, 1'b1, TNEW_LOAD);
    tick();
    drive_d(5'd0, 5'd9, 5'd0, 1'b0, 2'd0);
    bus.stall = 1'b1;
    #1;
    check("ld_fwdrt_d_e", 32'(bus.FwdRT_D), 32'(FWD_RF));
    tick();
    bus.stall = 1'b0;
    #1;
    check("ld_a3_e_bub", 32'(bus.A3_E), 0);
    check("ld_w_e_bub", 32'(bus.W_E), 0);
    check("ld_tnew_m", 32'(bus.Tnew_M), 1);
    check("ld_fwdrt_d_m", 32'(bus.FwdRT_D), 32'(FWD_RF));
    tick();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("ld_a3_w", 32'(bus.A3_W), 9);
    check("ld_a2_e", 32'(bus.A2_E), 9);
    check("ld_fwdrt_e", 32'(bus.FwdRT_E), 32'(FWD_W));
    check("ld_cnt", bus.stall_cnt, 1);
    flush();

    // Register 0 never forwards, even when written with Tnew 0.
    drive_d(5'd0, 5'd0, 5'd0, 1'b1, TNEW_LINK);
    tick();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("z_w_e", 32'(bus.W_E), 1);
    check("z_fwdrs_d", 32'(bus.FwdRS_D), 32'(FWD_RF));
    check("z_fwdrt_d", 32'(bus.FwdRT_D), 32'(FWD_RF));
    tick();
    check("z_fwdrs_e", 32'(bus.FwdRS_E), 32'(FWD_RF));
    check("z_fwdrt_e", 32'(bus.FwdRT_E), 32'(FWD_RF));
    tick();
    check("z_fwdrt_m", 32'(bus.FwdRT_M), 32'(FWD_RF));
    flush();

    // Priority: E, M and W all write r5 with Tnew 0.
    drive_d(5'd0, 5'd0, 5'd5, 1'b1, TNEW_LINK);
    repeat (3) tick();
    drive_d(5'd5, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("pri_e", 32'(bus.FwdRS_D), 32'(FWD_E));
    bus.stall = 1'b1;
    tick();
    bus.stall = 1'b0;
    #1;
    check("pri_m", 32'(bus.FwdRS_D), 32'(FWD_M));
    tick();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    #1;
    check("pri_w_d", 32'(bus.A3_W), 5);
    check("pri_w_e", 32'(bus.FwdRS_E), 32'(FWD_W));
    flush();

    // Store data in M fed from W.
    drive_d(5'd0, 5'd0, 5'd12, 1'b1, TNEW_ALU);
    tick();
    drive_d(5'd0, 5'd12, 5'd0, 1'b0, 2'd0);
    tick();
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    tick();
    check("st_a2_m", 32'(bus.A2_M), 12);
    check("st_fwdrt_m", 32'(bus.FwdRT_M), 32'(FWD_W));
    flush();

    // Mid-stream asynchronous reset with valid writers in E and M.
    drive_d(5'd0, 5'd0, 5'd7, 1'b1, TNEW_ALU);
    repeat (2) tick();
    check("mr_pre_w_e", 32'(bus.W_E), 1);
    check("mr_pre_w_m", 32'(bus.W_M), 1);
    #1;
    reset = 1'b1;
    #1;
    check("mr_w_e", 32'(bus.W_E), 0);
    check("mr_w_m", 32'(bus.W_M), 0);
    check("mr_a3_e", 32'(bus.A3_E), 0);
    check("mr_tnew_m", 32'(bus.Tnew_M), 0);
    check("mr_cnt", bus.stall_cnt, 0);
    #2;
    reset = 1'b0;
    drive_d(5'd0, 5'd0, 5'd0, 1'b0, 2'd0);
    tick();

    // Stall counter: 7 cycles, then 3 more; the 3-bit copy saturates.
    bus.stall  = 1'b1;
    bus3.stall = 1'b1;
    repeat (7) tick();
    check("cnt7", bus.stall_cnt, 7);
    check("cnt7_w3", 32'(bus3.stall_cnt), 7);
    repeat (3) tick();
    check("cnt10", bus.stall_cnt, 10);
    check("cnt_sat_w3", 32'(bus3.stall_cnt), 7);
    bus.stall  = 1'b0;
    bus3.stall = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
